gemm_tile_accelerator: RTL and testbench

- Signed 8-bit integer matrix-multiply engine: computes C = A·B, with A of size M×K, B of size K×N and C of size M×N.
- Operands come from two single-port, read-only SRAMs, one element per cycle each.
- Results go to a single-port, write-always output SRAM.
- The engine is output-stationary: it computes sqDim×sqDim tiles of C using an outer-product MAC array, then streams each finished tile to the C memory.

---
 rtl/gemm_accel_pkg.sv | 25 ++
 rtl/gemm_tile_accelerator_mac.sv | 51 +++++
 rtl/gemm_tile_accelerator.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gemm_tile_accelerator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_accel_pkg.sv
// Shared definitions for the GEMM tile accelerator.
//   state_e        : controller states
//   SQ_DIM, IN_W,
//   OUT_W          : default tile edge, operand width and accumulator width
//   elem_t, prod_t,
//   acc_t          : signed operand, full product and accumulator types
package gemm_accel_pkg;

  localparam int SQ_DIM = 4;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } state_e;

  typedef logic signed [IN_W-1:0]   elem_t;
  typedef logic signed [2*IN_W-1:0] prod_t;
  typedef logic signed [OUT_W-1:0]  acc_t;

endpackage

// File: rtl/gemm_tile_accelerator_mac.sv
// Outer-product accumulator array for one output tile.
// Ports:
//   clk_i      : clock
//   clr_i      : zero every accumulator on the next edge (wins over mac_en_i)
//   mac_en_i   : acc[i][j] += a_vec_i[i] * b_vec_i[j] for all i, j
//   a_vec_i    : column of A for the current k
//   b_vec_i    : row of B for the current k
//   rd_row_i,
//   rd_col_i   : accumulator selected onto rd_data_o (combinational)
//   rd_data_o  : selected accumulator value
// Accumulators are datapath state: they are cleared explicitly by the
// controller at job start and after each tile, never by reset.
module gemm_outer_mac
  import gemm_accel_pkg::*;
#(
  parameter int SqDim = SQ_DIM
) (
  input  logic                       clk_i,
  input  logic                       clr_i,
  input  logic                       mac_en_i,
  input  elem_t                      a_vec_i [SqDim],
  input  elem_t                      b_vec_i [SqDim],
  input  logic [$clog2(SqDim)-1:0]   rd_row_i,
  input  logic [$clog2(SqDim)-1:0]   rd_col_i,
  output acc_t                       rd_data_o
);

  acc_t acc_q [SqDim][SqDim];

  // Full 16-bit signed product, sign-extended, added with 32-bit wrap.
  function automatic acc_t mac_wrap(input acc_t acc, input elem_t a, input elem_t b);
    prod_t p;
    p = a * b;
    return acc + {{(OUT_W-2*IN_W){p[2*IN_W-1]}}, p};
  endfunction

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SqDim; i++) begin
      for (int j = 0; j < SqDim; j++) begin
        if (clr_i) begin
          acc_q[i][j] <= '0;
        end else if (mac_en_i) begin
          acc_q[i][j] <= mac_wrap(acc_q[i][j], a_vec_i[i], b_vec_i[j]);
        end
      end
    end
  end

  assign rd_data_o = acc_q[rd_row_i][rd_col_i];

endmodule

// File: rtl/gemm_tile_accelerator.sv
// Output-stationary signed int8 GEMM engine: C = A * B, computed in
// sqDim x sqDim tiles and streamed to a write-always C memory.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : start a job (honoured only in IDLE)
//   M_rows_i, K_cols_i,
//   N_cols_i                : matrix sizes, stable while busy
//   busy_o, done_o          : job in progress / one-cycle completion pulse
//   A_addr_o, A_rd_data_i   : A read port (row-major, data one cycle late)
//   B_addr_o, B_rd_data_i   : B read port (row-major, data one cycle late)
//   C_addr_o, C_wr_data_o   : C write port (row-major, written every edge)
// Optional: define GEMM_ACCEL_ASSERT_EN to compile simulation checks for
// misuse (start while busy, illegal or changing sizes, address overflow).
module gemm_tile_accelerator
  import gemm_accel_pkg::*;
#(
  parameter int AddrWidth     = 12,
  parameter int InDataWidth   = IN_W,
  parameter int OutDataWidth  = OUT_W,
  parameter int sqDim         = SQ_DIM,
  parameter int SizeAddrWidth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [SizeAddrWidth-1:0]       M_rows_i,
  input  logic [SizeAddrWidth-1:0]       K_cols_i,
  input  logic [SizeAddrWidth-1:0]       N_cols_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [AddrWidth-1:0]           A_addr_o,
  input  logic signed [InDataWidth-1:0]  A_rd_data_i,
  output logic [AddrWidth-1:0]           B_addr_o,
  input  logic signed [InDataWidth-1:0]  B_rd_data_i,
  output logic [AddrWidth-1:0]           C_addr_o,
  output logic signed [OutDataWidth-1:0] C_wr_data_o
);

  localparam int IdxW = $clog2(sqDim);
  localparam int WrW  = 2 * IdxW;
  localparam int WW   = 2 * SizeAddrWidth + IdxW + 2;

  state_e state_q, state_n;

  logic [SizeAddrWidth-1:0] k_q, tm_q, tn_q;
  logic [IdxW-1:0]          j_q;
  logic [WrW-1:0]           wr_q;

  logic [SizeAddrWidth-1:0] k_last, tm_last, tn_last;
  logic                     size_zero;
  logic                     wr_last, tile_last;

  logic                     busy_q, done_q;
  logic [AddrWidth-1:0]     c_addr_q;
  acc_t                     c_data_q;

  elem_t a_buf_q [sqDim-1];
  elem_t b_buf_q [sqDim-1];
  elem_t a_vec   [sqDim];
  elem_t b_vec   [sqDim];

  logic  acc_clr, mac_en;
  acc_t  acc_rd;

  logic [WW-1:0] tile_row, tile_col;

  function automatic logic [WW-1:0] lin_addr(input logic [WW-1:0] row,
                                             input logic [WW-1:0] col,
                                             input logic [WW-1:0] stride);
    return row * stride + col;
  endfunction

  assign k_last    = K_cols_i - 1'b1;
  assign tm_last   = (M_rows_i >> IdxW) - 1'b1;
  assign tn_last   = (N_cols_i >> IdxW) - 1'b1;
  assign size_zero = (M_rows_i == '0) || (K_cols_i == '0) || (N_cols_i == '0);
  assign wr_last   = (wr_q == '1);
  assign tile_last = (tm_q == tm_last) && (tn_q == tn_last);

  assign tile_row  = WW'(tm_q) * WW'(sqDim);
  assign tile_col  = WW'(tn_q) * WW'(sqDim);

  // ---- controller ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    acc_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        acc_clr = 1'b1;
        if (start_i) begin
          state_n = size_zero ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (j_q == IdxW'(sqDim - 1)) begin
          state_n = MAC;
        end
      end
      MAC: begin
        mac_en  = 1'b1;
        state_n = (k_q == k_last) ? WRITE : LOAD;
      end
      WRITE: begin
        if (wr_last) begin
          acc_clr = 1'b1;
          state_n = tile_last ? DONE : LOAD;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q  <= '0;
      j_q  <= '0;
      wr_q <= '0;
      tm_q <= '0;
      tn_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          k_q  <= '0;
          j_q  <= '0;
          wr_q <= '0;
          tm_q <= '0;
          tn_q <= '0;
        end
        LOAD: begin
          j_q <= j_q + 1'b1;
        end
        MAC: begin
          k_q <= (k_q == k_last) ? '0 : k_q + 1'b1;
        end
        WRITE: begin
          wr_q <= wr_q + 1'b1;
          if (wr_last) begin
            if (tn_q == tn_last) begin
              tn_q <= '0;
              tm_q <= tm_q + 1'b1;
            end else begin
              tn_q <= tn_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---- operand fetch: address in LOAD cycle j, data captured one cycle later ----
  assign A_addr_o = (state_q == LOAD)
                  ? AddrWidth'(lin_addr(tile_row + WW'(j_q), WW'(k_q), WW'(K_cols_i)))
                  : '0;
  assign B_addr_o = (state_q == LOAD)
                  ? AddrWidth'(lin_addr(WW'(k_q), tile_col + WW'(j_q), WW'(N_cols_i)))
                  : '0;

  always_ff @(posedge clk_i) begin
    if (state_q == LOAD && j_q != '0) begin
      a_buf_q[j_q - 1'b1] <= A_rd_data_i;
      b_buf_q[j_q - 1'b1] <= B_rd_data_i;
    end
  end

  // The last element arrives during MAC and feeds the array directly.
  always_comb begin
    for (int i = 0; i < sqDim - 1; i++) begin
      a_vec[i] = a_buf_q[i];
      b_vec[i] = b_buf_q[i];
    end
    a_vec[sqDim-1] = A_rd_data_i;
    b_vec[sqDim-1] = B_rd_data_i;
  end

  // ---- accumulate ----
  gemm_outer_mac #(
    .SqDim (sqDim)
  ) u_mac (
    .clk_i     (clk_i),
    .clr_i     (acc_clr),
    .mac_en_i  (mac_en),
    .a_vec_i   (a_vec),
    .b_vec_i   (b_vec),
    .rd_row_i  (wr_q[WrW-1:IdxW]),
    .rd_col_i  (wr_q[IdxW-1:0]),
    .rd_data_o (acc_rd)
  );

  // ---- result drain: registered C port holds the last pair between writes ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      busy_q <= (state_n != IDLE);
      done_q <= (state_q == DONE);
      if (state_q == WRITE) begin
        c_addr_q <= AddrWidth'(lin_addr(tile_row + WW'(wr_q[WrW-1:IdxW]),
                                        tile_col + WW'(wr_q[IdxW-1:0]),
                                        WW'(N_cols_i)));
        c_data_q <= acc_rd;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign C_addr_o    = c_addr_q;
  assign C_wr_data_o = c_data_q;

`ifdef GEMM_ACCEL_ASSERT_EN
  logic [SizeAddrWidth-1:0] m_seen_q, k_seen_q, n_seen_q;
  logic [WW-1:0]            a_addr_w, b_addr_w, c_addr_w;

  assign a_addr_w = lin_addr(tile_row + WW'(j_q), WW'(k_q), WW'(K_cols_i));
  assign b_addr_w = lin_addr(WW'(k_q), tile_col + WW'(j_q), WW'(N_cols_i));
  assign c_addr_w = lin_addr(tile_row + WW'(wr_q[WrW-1:IdxW]),
                             tile_col + WW'(wr_q[IdxW-1:0]), WW'(N_cols_i));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == IDLE && start_i) begin
        m_seen_q <= M_rows_i;
        k_seen_q <= K_cols_i;
        n_seen_q <= N_cols_i;
        if (M_rows_i[IdxW-1:0] != '0 || N_cols_i[IdxW-1:0] != '0)
          $error("gemm: M or N is not a multiple of the tile edge");
      end
      if (state_q != IDLE) begin
        if (start_i)
          $error("gemm: start while busy");
        if (M_rows_i != m_seen_q || K_cols_i != k_seen_q || N_cols_i != n_seen_q)
          $error("gemm: size inputs changed while busy");
      end
      if (state_q == LOAD && ((a_addr_w >> AddrWidth) != '0 || (b_addr_w >> AddrWidth) != '0))
        $error("gemm: operand address out of range");
      if (state_q == WRITE && (c_addr_w >> AddrWidth) != '0)
        $error("gemm: result address out of range");
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_accelerator.sv
module tb_gemm_tile_accelerator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         m_sz, k_sz, n_sz;
  logic               busy, done;
  logic [11:0]        a_addr, b_addr, c_addr;
  logic signed [7:0]  a_rd, b_rd;
  logic signed [31:0] c_wr;

  logic signed [7:0]  amem [4096];
  logic signed [7:0]  bmem [4096];
  int                 cmem [4096];
  int                 cexp [4096];

  int tests = 0;
  int fails = 0;

  gemm_tile_accelerator dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .M_rows_i    (m_sz),
    .K_cols_i    (k_sz),
    .N_cols_i    (n_sz),
    .busy_o      (busy),
    .done_o      (done),
    .A_addr_o    (a_addr),
    .A_rd_data_i (a_rd),
    .B_addr_o    (b_addr),
    .B_rd_data_i (b_rd),
    .C_addr_o    (c_addr),
    .C_wr_data_o (c_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rd <= amem[a_addr];
    b_rd <= bmem[b_addr];
    cmem[c_addr] <= c_wr;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain triple-loop reference with 32-bit wrap.
  task automatic golden(input int m, input int k, input int n);
    for (int mm = 0; mm < m; mm++) begin
      for (int nn = 0; nn < n; nn++) begin
        int s;
        s = 0;
        for (int kk = 0; kk < k; kk++)
          s += int'(amem[mm*k+kk]) * int'(bmem[kk*n+nn]);
        cexp[mm*n+nn] = s;
      end
    end
  endtask

  // Starts a job and returns the edge count (accept edge = 1) at which
  // done_o is first seen; a lost job returns the budget value.
  task automatic run_job(input int m, input int k, input int n, output int lat);
    @(negedge clk);
    m_sz  = 8'(m);
    k_sz  = 8'(k);
    n_sz  = 8'(n);
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    @(negedge clk);
    while (done !== 1'b1 && lat < 20000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    m_sz  = '0;
    k_sz  = '0;
    n_sz  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0)   begin fails++; $display("FAIL reset done: got %b expected 0", done); end
    tests++; if (a_addr !== 12'd0) begin fails++; $display("FAIL reset A_addr: got %0d expected 0", a_addr); end
    tests++; if (b_addr !== 12'd0) begin fails++; $display("FAIL reset B_addr: got %0d expected 0", b_addr); end
    tests++; if (c_addr !== 12'd0) begin fails++; $display("FAIL reset C_addr: got %0d expected 0", c_addr); end
    tests++; if (c_wr !== 32'sd0)  begin fails++; $display("FAIL reset C_data: got %0d expected 0", c_wr); end
    rst = 1'b0;
  endtask

  task automatic test_identity;
    int lat;
    for (int i = 0; i < 16; i++) begin
      amem[i] = (i / 4 == i % 4) ? 8'sd1 : 8'sd0;
      bmem[i] = 8'(i);
    end
    run_job(4, 4, 4, lat);
    tests++; if (lat !== 38) begin fails++; $display("FAIL identity latency: got %0d expected 38", lat); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL identity busy at done: got %b expected 0", busy); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cmem[i] !== i) begin fails++; $display("FAIL identity C[%0d]: got %0d expected %0d", i, cmem[i], i); end
    end
    @(posedge clk);
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL identity done width: got %b expected 0", done); end
    tests++; if (c_addr !== 12'd15) begin fails++; $display("FAIL identity C_addr hold: got %0d expected 15", c_addr); end
    tests++; if (c_wr !== 32'sd15) begin fails++; $display("FAIL identity C_data hold: got %0d expected 15", c_wr); end
  endtask

  task automatic test_neg_extreme;
    int lat;
    for (int i = 0; i < 64; i++) begin
      amem[i] = -8'sd128;
      bmem[i] = -8'sd128;
    end
    run_job(8, 8, 8, lat);
    tests++; if (lat !== 226) begin fails++; $display("FAIL neg latency: got %0d expected 226", lat); end
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (cmem[i] !== 131072) begin fails++; $display("FAIL neg C[%0d]: got %0d expected 131072", i, cmem[i]); end
    end
  endtask

  task automatic test_k1;
    int lat;
    for (int i = 0; i < 4; i++) amem[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) bmem[i] = 8'(i + 1);
    run_job(4, 1, 8, lat);
    tests++; if (lat !== 44) begin fails++; $display("FAIL k1 latency: got %0d expected 44", lat); end
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 8; n++) begin
        tests++;
        if (cmem[m*8+n] !== (m + 1) * (n + 1)) begin
          fails++;
          $display("FAIL k1 C[%0d][%0d]: got %0d expected %0d", m, n, cmem[m*8+n], (m + 1) * (n + 1));
        end
      end
    end
  endtask

  task automatic test_zero_size;
    int lat;
    run_job(0, 4, 4, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL zero M latency: got %0d expected 2", lat); end
    run_job(4, 0, 4, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL zero K latency: got %0d expected 2", lat); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 10; t++) begin
      int m, k, n, lat, exp_lat;
      m = 4 * $urandom_range(1, 8);
      k = 4 * $urandom_range(1, 8);
      n = 4 * $urandom_range(1, 8);
      for (int i = 0; i < m * k; i++) amem[i] = 8'($urandom);
      for (int i = 0; i < k * n; i++) bmem[i] = 8'($urandom);
      golden(m, k, n);
      run_job(m, k, n, lat);
      exp_lat = (m / 4) * (n / 4) * (k * 5 + 16) + 2;
      tests++;
      if (lat !== exp_lat) begin fails++; $display("FAIL random%0d latency: got %0d expected %0d", t, lat, exp_lat); end
      for (int i = 0; i < m * n; i++) begin
        tests++;
        if (cmem[i] !== cexp[i]) begin
          fails++;
          if (fails < 40) $display("FAIL random%0d C[%0d]: got %0d expected %0d", t, i, cmem[i], cexp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int lat, dn;
    for (int i = 0; i < 256; i++) begin
      amem[i] = 8'($urandom);
      bmem[i] = 8'($urandom);
    end
    golden(16, 16, 16);
    @(negedge clk);
    m_sz  = 8'd16;
    k_sz  = 8'd16;
    n_sz  = 8'd16;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0;
    for (int c = 0; c < 84; c++) begin
      @(posedge clk);
      #1 if (done === 1'b1) dn++;
    end
    @(negedge clk);
    // WRITE began after 80 edges; the fourth drained element is C[0][3].
    tests++; if (c_addr !== 12'd3) begin fails++; $display("FAIL midwrite C_addr: got %0d expected 3", c_addr); end
    tests++; if (c_wr !== cexp[3]) begin fails++; $display("FAIL midwrite C_data: got %0d expected %0d", c_wr, cexp[3]); end
    tests++; if (dn !== 0) begin fails++; $display("FAIL midwrite early done: got %0d expected 0", dn); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort done: got %b expected 0", done); end
    tests++; if (c_addr !== 12'd0) begin fails++; $display("FAIL abort C_addr: got %0d expected 0", c_addr); end
    tests++; if (a_addr !== 12'd0) begin fails++; $display("FAIL abort A_addr: got %0d expected 0", a_addr); end
    run_job(16, 16, 16, lat);
    tests++; if (lat !== 1538) begin fails++; $display("FAIL restart latency: got %0d expected 1538", lat); end
    for (int i = 0; i < 256; i++) begin
      tests++;
      if (cmem[i] !== cexp[i]) begin
        fails++;
        if (fails < 40) $display("FAIL restart C[%0d]: got %0d expected %0d", i, cmem[i], cexp[i]);
      end
    end
  endtask

  task automatic test_start_busy;
    int cnt, dn, first;
    for (int i = 0; i < 16; i++) begin
      amem[i] = (i / 4 == i % 4) ? 8'sd1 : 8'sd0;
      bmem[i] = 8'(100 - i);
    end
    @(negedge clk);
    m_sz  = 8'd4;
    k_sz  = 8'd4;
    n_sz  = 8'd4;
    start = 1'b1;
    @(posedge clk);
    cnt   = 1;
    dn    = 0;
    first = 0;
    while (cnt < 80) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dn++;
        if (first == 0) first = cnt;
      end
      start = (cnt == 3 || cnt == 10 || cnt == 20 || cnt == 37);
      @(posedge clk);
      cnt++;
    end
    @(negedge clk);
    start = 1'b0;
    tests++; if (dn !== 1) begin fails++; $display("FAIL busy-start done count: got %0d expected 1", dn); end
    tests++; if (first !== 38) begin fails++; $display("FAIL busy-start latency: got %0d expected 38", first); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy-start idle: got %b expected 0", busy); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (cmem[i] !== 100 - i) begin fails++; $display("FAIL busy-start C[%0d]: got %0d expected %0d", i, cmem[i], 100 - i); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      amem[i] = '0;
      bmem[i] = '0;
      cmem[i] = 0;
    end
    test_reset;
    test_identity;
    test_neg_extreme;
    test_k1;
    test_zero_size;
    test_random;
    test_reset_mid_write;
    test_start_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
